rd_req_queue: RTL and testbench

RD_REQ_QUEUE -- requirements
Module: rd_req_queue

---
 rtl/rd_req_queue_pkg.sv | 19 +
 rtl/rd_req_queue_if.sv | 40 ++++
 rtl/rd_req_queue_rq_fifo.sv | 60 ++++++
 rtl/rd_req_queue.sv | 115 +++++++++++
 tb/tb_rd_req_queue.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rd_req_queue_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the read request queue.
package rd_req_queue_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int ID_W_DEF   = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 128;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Occupancy counter must hold the value DEPTH itself, not just DEPTH-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rd_req_queue_if.sv
// Client request, read-channel and response signals of the read request queue.
interface rd_req_queue_if
  import rd_req_queue_pkg::*;
#(
  parameter int ID_W   = ID_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rqfull_1;

  logic              rstart_rq;
  logic [ADDR_W-1:0] rin_addr;
  logic [ID_W-1:0]   next_rid;

  logic [DATA_W-1:0] rdat_m_data;
  logic              rdat_m_valid;
  logic              finish_mrd;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [ID_W-1:0]   resp_id;
  logic              err_stray;

  modport slave (
    input  req_valid, req_addr, rdat_m_data, rdat_m_valid, finish_mrd,
    output req_ready, rqfull_1, rstart_rq, rin_addr, next_rid,
           resp_valid, resp_data, resp_id, err_stray
  );

  modport master (
    output req_valid, req_addr, rdat_m_data, rdat_m_valid, finish_mrd,
    input  req_ready, rqfull_1, rstart_rq, rin_addr, next_rid,
           resp_valid, resp_data, resp_id, err_stray
  );

endinterface

// File: rtl/rd_req_queue_rq_fifo.sv
// Synchronous address FIFO with push/pop/count; pointers wrap mod DEPTH.
module rq_fifo
  import rd_req_queue_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        empty
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);

endmodule

// File: rtl/rd_req_queue.sv
// Read request queue: buffers client addresses and runs one read at a time,
// tagging each with a rolling ID and forwarding returned data beats.
//
// state | meaning
// IDLE  | no read in flight; starts the head request when the queue is non-empty
// BUSY  | one read in flight; data beats forwarded until finish_mrd
module rd_req_queue
  import rd_req_queue_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ID_W   = ID_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic         clk,
  input  logic         rst,
  rd_req_queue_if.slave bus
);

  localparam int CNT_W = cnt_width(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic              start;
  logic              beat;
  logic              stray;
  logic              push;

  logic [ADDR_W-1:0] head_addr;
  logic [CNT_W-1:0]  count;
  logic              empty;

  logic [ID_W-1:0]   id_cnt;
  logic [ID_W-1:0]   cur_id;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [ID_W-1:0]   resp_id_q;
  logic              err_stray_q;

  assign bus.req_ready = (count < CNT_W'(DEPTH));
  assign bus.rqfull_1  = (count >= CNT_W'(DEPTH - 1));
  assign push          = bus.req_valid && bus.req_ready;

  rq_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_rq_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (start),
    .din   (bus.req_addr),
    .dout  (head_addr),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    beat      = 1'b0;
    stray     = 1'b0;
    case (state)
      IDLE: begin
        stray = bus.rdat_m_valid || bus.finish_mrd;
        // Held off during reset so the start pulse reads as 0 in the reset cycle.
        if (!empty && !rst) begin
          start     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        beat = bus.rdat_m_valid;
        if (bus.finish_mrd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_cnt       <= '0;
      cur_id       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      err_stray_q  <= 1'b0;
    end else begin
      resp_valid_q <= beat;
      if (start) begin
        cur_id <= id_cnt;
        id_cnt <= id_cnt + 1'b1;
      end
      if (beat) begin
        resp_data_q <= bus.rdat_m_data;
        resp_id_q   <= cur_id;
      end
      if (stray) err_stray_q <= 1'b1;
    end
  end

  assign bus.rstart_rq  = start;
  assign bus.rin_addr   = start ? head_addr : '0;
  assign bus.next_rid   = start ? id_cnt : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.err_stray  = err_stray_q;

endmodule

// File: tb/tb_rd_req_queue.sv
// Directed self-checking bench for rd_req_queue.
module tb_rd_req_queue;

  localparam int DEPTH  = 4;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  localparam logic [DATA_W-1:0] D1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [DATA_W-1:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DATA_W-1:0] D3 = 128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555;
  localparam logic [DATA_W-1:0] D4 = 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rd_req_queue_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rd_req_queue #(
    .DEPTH  (DEPTH),
    .ID_W   (ID_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || bus.rqfull_1 !== 1'b0 || bus.rstart_rq !== 1'b0 ||
        bus.resp_valid !== 1'b0 || bus.err_stray !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: ready=%b rqfull_1=%b rstart=%b resp_valid=%b err_stray=%b, expected 1 0 0 0 0",
               bus.req_ready, bus.rqfull_1, bus.rstart_rq, bus.resp_valid, bus.err_stray);
    end
    tests++;
    if (bus.rin_addr !== '0 || bus.next_rid !== '0 || bus.resp_data !== '0 || bus.resp_id !== '0) begin
      fails++;
      $display("FAIL reset_values: rin_addr=%h next_rid=%0d resp_data=%h resp_id=%0d, expected all 0",
               bus.rin_addr, bus.next_rid, bus.resp_data, bus.resp_id);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hDEADBEEF;
    @(negedge clk);
    tests++;
    if (bus.rstart_rq !== 1'b0) begin
      fails++;
      $display("FAIL single_no_early_start: rstart=%b, expected 0", bus.rstart_rq);
    end
    step();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    @(negedge clk);
    tests++;
    if (bus.rstart_rq !== 1'b1 || bus.rin_addr !== 32'hDEADBEEF || bus.next_rid !== 4'd0) begin
      fails++;
      $display("FAIL single_start: rstart=%b rin_addr=%h next_rid=%0d, expected 1 deadbeef 0",
               bus.rstart_rq, bus.rin_addr, bus.next_rid);
    end
    step();
    @(negedge clk);
    tests++;
    if (bus.rstart_rq !== 1'b0) begin
      fails++;
      $display("FAIL single_start_pulse: rstart=%b, expected 0", bus.rstart_rq);
    end
    repeat (3) step();
    bus.rdat_m_valid = 1'b1;
    bus.rdat_m_data  = D1;
    @(negedge clk);
    tests++;
    if (bus.resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_resp_latency: resp_valid=%b, expected 0", bus.resp_valid);
    end
    step();
    bus.rdat_m_valid = 1'b0;
    bus.rdat_m_data  = '0;
    bus.finish_mrd   = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== D1 || bus.resp_id !== 4'd0) begin
      fails++;
      $display("FAIL single_resp: resp_valid=%b resp_data=%h resp_id=%0d, expected 1 %h 0",
               bus.resp_valid, bus.resp_data, bus.resp_id, D1);
    end
    step();
    bus.finish_mrd = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== D1 || bus.rstart_rq !== 1'b0 ||
        bus.err_stray !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_idle: resp_valid=%b resp_data=%h rstart=%b err_stray=%b ready=%b, expected 0 %h 0 0 1",
               bus.resp_valid, bus.resp_data, bus.rstart_rq, bus.err_stray, bus.req_ready, D1);
    end
    step();
  endtask

  task automatic test_fill();
    logic [4:0] exp_full;
    logic [4:0] exp_ready;
    exp_full  = 5'b11100;
    exp_ready = 5'b00111;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hA000_0000;
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rstart_rq !== 1'b1 || bus.next_rid !== 4'd1) begin
      fails++;
      $display("FAIL fill_start: rstart=%b next_rid=%0d, expected 1 1", bus.rstart_rq, bus.next_rid);
    end
    step();
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'hB000_0001 + k;
      step();
      @(negedge clk);
      tests++;
      if (bus.rqfull_1 !== exp_full[k] || bus.req_ready !== exp_ready[k]) begin
        fails++;
        $display("FAIL fill_push%0d: rqfull_1=%b ready=%b, expected %b %b",
                 k + 1, bus.rqfull_1, bus.req_ready, exp_full[k], exp_ready[k]);
      end
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    for (int k = 0; k < 4; k++) begin
      bus.finish_mrd = 1'b1;
      step();
      bus.finish_mrd = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.rstart_rq !== 1'b1 || bus.rin_addr !== 32'hB000_0001 + k || bus.next_rid !== 4'(2 + k)) begin
        fails++;
        $display("FAIL fill_drain%0d: rstart=%b rin_addr=%h next_rid=%0d, expected 1 %h %0d",
                 k, bus.rstart_rq, bus.rin_addr, bus.next_rid, 32'hB000_0001 + k, 2 + k);
      end
      step();
    end
    bus.finish_mrd = 1'b1;
    step();
    bus.finish_mrd = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rstart_rq !== 1'b0 || bus.req_ready !== 1'b1 || bus.rqfull_1 !== 1'b0) begin
      fails++;
      $display("FAIL fill_fifth_ignored: rstart=%b ready=%b rqfull_1=%b, expected 0 1 0",
               bus.rstart_rq, bus.req_ready, bus.rqfull_1);
    end
    step();
  endtask

  task automatic test_id_wrap();
    logic [3:0] exp_rid;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_0100 + i;
      step();
      bus.req_valid = 1'b0;
      exp_rid = (i < 16) ? i[3:0] : 4'd0;
      @(negedge clk);
      tests++;
      if (bus.rstart_rq !== 1'b1 || bus.next_rid !== exp_rid || bus.rin_addr !== 32'h0000_0100 + i) begin
        fails++;
        $display("FAIL id_wrap_read%0d: rstart=%b next_rid=%0d rin_addr=%h, expected 1 %0d %h",
                 i, bus.rstart_rq, bus.next_rid, bus.rin_addr, exp_rid, 32'h0000_0100 + i);
      end
      step();
      bus.finish_mrd = 1'b1;
      step();
      bus.finish_mrd = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hC000_0000;
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rstart_rq !== 1'b1 || bus.rin_addr !== 32'hC000_0000 || bus.next_rid !== 4'd0) begin
      fails++;
      $display("FAIL sim_start0: rstart=%b rin_addr=%h next_rid=%0d, expected 1 c0000000 0",
               bus.rstart_rq, bus.rin_addr, bus.next_rid);
    end
    step();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hC000_0001;
    step();
    bus.req_addr  = 32'hC000_0002;
    step();
    bus.req_valid = 1'b0;
    bus.finish_mrd = 1'b1;
    step();
    bus.finish_mrd = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'hC000_0003;
    @(negedge clk);
    tests++;
    if (bus.rstart_rq !== 1'b1 || bus.rin_addr !== 32'hC000_0001 || bus.next_rid !== 4'd1) begin
      fails++;
      $display("FAIL sim_push_pop_start: rstart=%b rin_addr=%h next_rid=%0d, expected 1 c0000001 1",
               bus.rstart_rq, bus.rin_addr, bus.next_rid);
    end
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rqfull_1 !== 1'b0 || bus.req_ready !== 1'b1 || bus.rstart_rq !== 1'b0) begin
      fails++;
      $display("FAIL sim_count_kept: rqfull_1=%b ready=%b rstart=%b, expected 0 1 0",
               bus.rqfull_1, bus.req_ready, bus.rstart_rq);
    end
    bus.rdat_m_valid = 1'b1;
    bus.rdat_m_data  = D2;
    bus.finish_mrd   = 1'b1;
    step();
    bus.rdat_m_valid = 1'b0;
    bus.rdat_m_data  = '0;
    bus.finish_mrd   = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== D2 || bus.resp_id !== 4'd1 ||
        bus.rstart_rq !== 1'b1 || bus.rin_addr !== 32'hC000_0002 || bus.next_rid !== 4'd2) begin
      fails++;
      $display("FAIL sim_data_and_finish: resp_valid=%b resp_id=%0d rstart=%b rin_addr=%h next_rid=%0d, expected 1 1 1 c0000002 2",
               bus.resp_valid, bus.resp_id, bus.rstart_rq, bus.rin_addr, bus.next_rid);
    end
    step();
    @(negedge clk);
    tests++;
    if (bus.resp_valid !== 1'b0 || bus.rstart_rq !== 1'b0) begin
      fails++;
      $display("FAIL sim_single_resp: resp_valid=%b rstart=%b, expected 0 0", bus.resp_valid, bus.rstart_rq);
    end
    bus.finish_mrd = 1'b1;
    step();
    bus.finish_mrd = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rstart_rq !== 1'b1 || bus.rin_addr !== 32'hC000_0003 || bus.next_rid !== 4'd3) begin
      fails++;
      $display("FAIL sim_last_start: rstart=%b rin_addr=%h next_rid=%0d, expected 1 c0000003 3",
               bus.rstart_rq, bus.rin_addr, bus.next_rid);
    end
    step();
    bus.finish_mrd = 1'b1;
    step();
    bus.finish_mrd = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rstart_rq !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL sim_queue_empty: rstart=%b ready=%b, expected 0 1", bus.rstart_rq, bus.req_ready);
    end
    step();
  endtask

  task automatic test_stray();
    @(negedge clk);
    tests++;
    if (bus.err_stray !== 1'b0) begin
      fails++;
      $display("FAIL stray_initial: err_stray=%b, expected 0", bus.err_stray);
    end
    bus.rdat_m_valid = 1'b1;
    bus.rdat_m_data  = D3;
    step();
    bus.rdat_m_valid = 1'b0;
    bus.rdat_m_data  = '0;
    @(negedge clk);
    tests++;
    if (bus.resp_valid !== 1'b0 || bus.err_stray !== 1'b1 || bus.resp_data !== D2) begin
      fails++;
      $display("FAIL stray_data_dropped: resp_valid=%b err_stray=%b resp_data=%h, expected 0 1 %h",
               bus.resp_valid, bus.err_stray, bus.resp_data, D2);
    end
    repeat (3) step();
    @(negedge clk);
    tests++;
    if (bus.err_stray !== 1'b1) begin
      fails++;
      $display("FAIL stray_sticky: err_stray=%b, expected 1", bus.err_stray);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.err_stray !== 1'b0) begin
      fails++;
      $display("FAIL stray_cleared: err_stray=%b, expected 0", bus.err_stray);
    end
    bus.finish_mrd = 1'b1;
    step();
    bus.finish_mrd = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.err_stray !== 1'b1 || bus.resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL stray_finish: err_stray=%b resp_valid=%b, expected 1 0", bus.err_stray, bus.resp_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hD000_0000;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.finish_mrd = 1'b1;
    step();
    bus.finish_mrd = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'hE000_0000;
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rstart_rq !== 1'b1 || bus.next_rid !== 4'd1) begin
      fails++;
      $display("FAIL midrst_start: rstart=%b next_rid=%0d, expected 1 1", bus.rstart_rq, bus.next_rid);
    end
    step();
    for (int k = 1; k <= 3; k++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'hE000_0000 + k;
      step();
    end
    bus.req_valid    = 1'b0;
    bus.rdat_m_valid = 1'b1;
    bus.rdat_m_data  = D4;
    step();
    bus.rdat_m_valid = 1'b0;
    bus.rdat_m_data  = '0;
    @(negedge clk);
    tests++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== D4 || bus.resp_id !== 4'd1 ||
        bus.rqfull_1 !== 1'b1 || bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_busy: resp_valid=%b resp_data=%h resp_id=%0d rqfull_1=%b ready=%b, expected 1 %h 1 1 1",
               bus.resp_valid, bus.resp_data, bus.resp_id, bus.rqfull_1, bus.req_ready, D4);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || bus.rqfull_1 !== 1'b0 || bus.rstart_rq !== 1'b0 ||
        bus.resp_valid !== 1'b0 || bus.rin_addr !== '0 || bus.next_rid !== '0 ||
        bus.resp_data !== '0 || bus.resp_id !== '0 || bus.err_stray !== 1'b0) begin
      fails++;
      $display("FAIL midrst_outputs: ready=%b rqfull_1=%b rstart=%b resp_valid=%b rin_addr=%h next_rid=%0d resp_data=%h resp_id=%0d err_stray=%b, expected reset values",
               bus.req_ready, bus.rqfull_1, bus.rstart_rq, bus.resp_valid, bus.rin_addr,
               bus.next_rid, bus.resp_data, bus.resp_id, bus.err_stray);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      tests++;
      if (bus.rstart_rq !== 1'b0 || bus.req_ready !== 1'b1) begin
        fails++;
        $display("FAIL midrst_flushed%0d: rstart=%b ready=%b, expected 0 1", k, bus.rstart_rq, bus.req_ready);
      end
    end
    bus.finish_mrd = 1'b1;
    step();
    bus.finish_mrd = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.err_stray !== 1'b1) begin
      fails++;
      $display("FAIL midrst_late_finish: err_stray=%b, expected 1", bus.err_stray);
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hF000_000F;
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rstart_rq !== 1'b1 || bus.rin_addr !== 32'hF000_000F || bus.next_rid !== 4'd0) begin
      fails++;
      $display("FAIL midrst_new_push: rstart=%b rin_addr=%h next_rid=%0d, expected 1 f000000f 0",
               bus.rstart_rq, bus.rin_addr, bus.next_rid);
    end
    step();
    bus.finish_mrd = 1'b1;
    step();
    bus.finish_mrd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_addr     = '0;
    bus.rdat_m_data  = '0;
    bus.rdat_m_valid = 1'b0;
    bus.finish_mrd   = 1'b0;
    test_reset();
    test_single_read();
    test_fill();
    test_id_wrap();
    test_simultaneous();
    test_stray();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
